regfile8x16: RTL
================

Name: regfile8x16

Overview:
- 8-entry × 16-bit register bank, one write port and two read ports.
- Sits directly upstream of the 8:1 bit-mux stage: the bank's eight register outputs feed one mux8 per bit per read port, with the 3-bit read address as select.
- Supplies operand A/B to the CPU datapath; written from the writeback bus.
- Structural style: gate/flop cells plus existing mux8 instances, no behavioural register arrays.

Parameters:
- WIDTH, 16, data width of each register and of every data port.
- ZERO_R0, 0, when 1 register 0 is hardwired to zero: writes to it are ignored and reads return 0.
- BYPASS, 0, when 1 a read of the address being written in the same cycle returns wdata (write-through); when 0 it returns the stored value.

Ports:
- clk  input  1  rising-edge clock, sole clock.
- rst  input  1  synchronous, active-high reset.
- we  input  1  write enable.
- waddr  input  3  write register index.
- wdata  input  WIDTH  write data.
- raddr_a  input  3  read port A index.
- raddr_b  input  3  read port B index.
- rdata_a  output  WIDTH  read port A data.
- rdata_b  output  WIDTH  read port B data.
- wr_ack  output  1  registered pulse, high for the one cycle after an accepted write.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst). All state changes occur only on the rising edge of clk.
- Reset: with rst=1 at an edge, all 8 registers become 0 and wr_ack becomes 0.
  - rst overrides we in the same cycle; the write is dropped.
  - Consequence after reset: rdata_a=rdata_b=0 for every address.
- Write:
  - The 3→8 decoder of waddr, gated by we, drives per-register load enables.
  - An enabled register captures wdata at the edge; all other registers hold.
  - Exactly one register loads per write.
  - With ZERO_R0=1 and waddr=0, no register loads, but wr_ack still pulses (the write is accepted and discarded).
- wr_ack:
  - wr_ack(t+1) = we(t) & ~rst(t).
  - Back-to-back writes keep wr_ack high continuously.
- Read:
  - Combinational, zero-cycle latency: rdata_x = reg[raddr_x], selected through one mux8 per bit.
  - Ports A and B are fully independent; both may address the same register.
- Same-cycle read/write hazard (we=1, raddr_x==waddr):
  - BYPASS=0: rdata_x shows the old value during that cycle and the new value from the next cycle.
  - BYPASS=1: rdata_x = wdata combinationally (2:1 mux per bit, select = we & addr-equal compare). Under ZERO_R0=1 with address 0, the bypass is suppressed and 0 is returned.
- Address range: all 3-bit values are valid; there is no out-of-range case.
- X handling: none required; inputs are assumed driven. The stored values of unaddressed registers must never change on a write.
- Reset mid-stream: a write coincident with rst is lost, and the register reads 0 on the next cycle.

Decomposition:
- Shared constants file (included by the CPU top): REG_COUNT=8, REG_ADDR_W=3, DATA_W=16.
- Sub-module dffe_sr: 1-bit D flip-flop with synchronous active-high reset and load enable.
  - Built from the existing 2:1 mux cell (hold/load) feeding a plain DFF, with reset forcing D=0.
  - Instantiated WIDTH×8 times via generate.
- Sub-module dec3to8: write-address decoder built from the NAND/NOT gate cells, with an enable input.
- Read ports reuse the existing mux8 cell, WIDTH instances per port.

Test Plan:
- Reset: preload all regs with 16'hFFFF, assert rst with we=1, waddr=3, wdata=16'h1234 → all 8 addresses on both ports read 16'h0000; wr_ack=0.
- Fill and read: write reg i ← 16'h1111*i for i=0..7 (ZERO_R0=0); sweep raddr_a=0..7 and raddr_b=7..0 → port A returns 16'h0000, 16'h1111 … 16'h7777 in order; port B returns the same values in reverse order.
- Isolation: write reg5 ← 16'hA5A5, then reg5 ← 16'h5A5A; all other registers are unchanged from the fill pattern; wr_ack is high for 2 consecutive cycles.
- Hazard with BYPASS=0: reg2=16'h0002; in one cycle drive we=1, waddr=2, wdata=16'hBEEF, raddr_a=2 → rdata_a=16'h0002 that cycle, 16'hBEEF the next. With BYPASS=1 → rdata_a=16'hBEEF in the same cycle.
- ZERO_R0=1: write reg0 ← 16'hDEAD → reads of reg0 give 16'h0000 on both ports, both in the same cycle (BYPASS=1) and afterwards; wr_ack still pulses.
- Dual-port same address: raddr_a=raddr_b=6 with reg6=16'hC0DE → both outputs are 16'hC0DE; then we=0 with changing wdata → no register changes.

Source files
------------

// File: rtl/regfile8x16_pkg.sv
// regfile8x16_pkg: shared register-bank constants and types
package regfile8x16_pkg;
  localparam int REG_COUNT  = 8;
  localparam int REG_ADDR_W = 3;
  localparam int DATA_W     = 16;
  typedef logic [REG_ADDR_W-1:0] addr_t;
endpackage

// File: rtl/regfile8x16_if.sv
// regfile8x16_if: write/read bus of the register bank
interface regfile8x16_if #(parameter int WIDTH = regfile8x16_pkg::DATA_W);
  import regfile8x16_pkg::*;
  logic             we;
  addr_t            waddr;
  logic [WIDTH-1:0] wdata;
  addr_t            raddr_a;
  addr_t            raddr_b;
  logic [WIDTH-1:0] rdata_a;
  logic [WIDTH-1:0] rdata_b;
  logic             wr_ack;
  modport master (output we, waddr, wdata, raddr_a, raddr_b, input rdata_a, rdata_b, wr_ack);
  modport slave  (input we, waddr, wdata, raddr_a, raddr_b, output rdata_a, rdata_b, wr_ack);
endinterface

// File: rtl/regfile8x16_cells.sv
// regfile8x16_cells: gate/flop cells and the bit-slice flop and write decoder built from them
module mux2 (
  input  logic i_a,
  input  logic i_b,
  input  logic i_s,
  output logic o_y
);
  assign o_y = i_s ? i_b : i_a;
endmodule

module mux8 (
  input  logic [7:0] i_d,
  input  logic [2:0] i_s,
  output logic       o_y
);
  assign o_y = i_d[i_s];
endmodule

module dff (
  input  logic clk,
  input  logic i_d,
  output logic o_q
);
  always_ff @(posedge clk) o_q <= i_d;
endmodule

module inv (
  input  logic i_a,
  output logic o_y
);
  assign o_y = ~i_a;
endmodule

module nand4 (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  input  logic i_d,
  output logic o_y
);
  assign o_y = ~(i_a & i_b & i_c & i_d);
endmodule

module dffe_sr (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_d,
  output logic o_q
);
  logic w_hold, w_d;
  mux2 u_load (.i_a(o_q), .i_b(i_d), .i_s(i_en), .o_y(w_hold));
  mux2 u_rst  (.i_a(w_hold), .i_b(1'b0), .i_s(rst), .o_y(w_d));
  dff  u_ff   (.clk(clk), .i_d(w_d), .o_q(o_q));
endmodule

module dec3to8 (
  input  logic       i_en,
  input  logic [2:0] i_a,
  output logic [7:0] o_y
);
  logic [2:0] w_an;
  for (genvar k = 0; k < 3; k++) begin : g_inv
    inv u_inv (.i_a(i_a[k]), .o_y(w_an[k]));
  end
  for (genvar i = 0; i < 8; i++) begin : g_out
    logic w_n;
    nand4 u_nand (
      .i_a(i_en),
      .i_b(((i >> 2) & 1) != 0 ? i_a[2] : w_an[2]),
      .i_c(((i >> 1) & 1) != 0 ? i_a[1] : w_an[1]),
      .i_d((i & 1) != 0 ? i_a[0] : w_an[0]),
      .o_y(w_n)
    );
    inv u_out (.i_a(w_n), .o_y(o_y[i]));
  end
endmodule

// File: rtl/regfile8x16.sv
// regfile8x16: 8x16 register bank, one write port, two combinational read ports
module regfile8x16
  import regfile8x16_pkg::*;
#(
  parameter int WIDTH   = DATA_W,
  parameter bit ZERO_R0 = 1'b0,
  parameter bit BYPASS  = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  regfile8x16_if.slave   bus
);
  logic [REG_COUNT-1:0]            w_ld;
  logic [REG_COUNT-1:0][WIDTH-1:0] w_q;
  logic                            w_wz, w_hit_a, w_hit_b;
  dec3to8 u_dec (.i_en(bus.we), .i_a(bus.waddr), .o_y(w_ld));
  for (genvar r = 0; r < REG_COUNT; r++) begin : g_reg
    if (ZERO_R0 && r == 0) begin : g_zero
      assign w_q[r] = '0;
    end else begin : g_bits
      for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        dffe_sr u_ff (.clk(clk), .rst(rst), .i_en(w_ld[r]), .i_d(bus.wdata[b]), .o_q(w_q[r][b]));
      end
    end
  end
  // bypass never forwards a write aimed at a hardwired-zero r0
  assign w_wz    = ZERO_R0 && bus.waddr == '0;
  assign w_hit_a = BYPASS && bus.we && !w_wz && bus.raddr_a == bus.waddr;
  assign w_hit_b = BYPASS && bus.we && !w_wz && bus.raddr_b == bus.waddr;
  for (genvar b = 0; b < WIDTH; b++) begin : g_rd
    logic [REG_COUNT-1:0] w_col;
    logic                 w_ra, w_rb;
    for (genvar r = 0; r < REG_COUNT; r++) begin : g_col
      assign w_col[r] = w_q[r][b];
    end
    mux8 u_mux_a (.i_d(w_col), .i_s(bus.raddr_a), .o_y(w_ra));
    mux8 u_mux_b (.i_d(w_col), .i_s(bus.raddr_b), .o_y(w_rb));
    mux2 u_byp_a (.i_a(w_ra), .i_b(bus.wdata[b]), .i_s(w_hit_a), .o_y(bus.rdata_a[b]));
    mux2 u_byp_b (.i_a(w_rb), .i_b(bus.wdata[b]), .i_s(w_hit_b), .o_y(bus.rdata_b[b]));
  end
  dffe_sr u_ack (.clk(clk), .rst(rst), .i_en(1'b1), .i_d(bus.we), .o_q(bus.wr_ack));
endmodule
